// File: rtl/ipv4_vlg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ipv4_vlg_pkg
//  Description : Shared types for the IPv4 transmit path: stream beat,
//                packet metadata and the TX arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ipv4_vlg_pkg;

    // Width of the saturating watchdog counter used by the TX arbiter
    localparam int CNT_W = 16;

    // One stream beat: data byte plus framing flags
    typedef struct packed {
        logic [7:0] dat;
        logic       val;
        logic       sof;
        logic       eof;
    } ipv4_strm_t;

    // Per-packet metadata handed to the transmit engine with the stream
    typedef struct packed {
        logic [31:0] dst_ip;
        logic [15:0] len;
        logic [7:0]  proto;
    } ipv4_meta_t;

    // Arbiter states; kept here so assertion modules can bind against them
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } ipv4_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_vlg_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : eth_vlg_rr_pick
//  Description : Combinational round-robin picker. Returns the first set
//                request at or above ptr, wrapping past N-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_vlg_rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] cand;

    // Scan from the farthest offset down to ptr so the closest request wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ipv4_vlg_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ipv4_vlg_tx_arb
//  Description : Round-robin arbiter sharing one IPv4 transmit engine among
//                N sources. Muxes the granted source's stream/metadata to the
//                engine and routes the engine handshake back to it only.
//                Grant is released on done, on requester withdrawal, or on a
//                watchdog timeout (tmo pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module ipv4_vlg_tx_arb
    import ipv4_vlg_pkg::*;
#(
    parameter int N            = 3,
    parameter int W            = $clog2(N),
    parameter int ACC_TIMEOUT  = 1024,
    parameter int DONE_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    // requester side
    input  ipv4_strm_t [N-1:0]   ipv4_in_strm,
    input  ipv4_meta_t [N-1:0]   ipv4_in_meta,
    input  logic       [N-1:0]   ipv4_in_rdy,
    output logic       [N-1:0]   ipv4_in_req,
    output logic       [N-1:0]   ipv4_in_acc,
    output logic       [N-1:0]   ipv4_in_done,
    // engine side
    output ipv4_strm_t           ipv4_out_strm,
    output ipv4_meta_t           ipv4_out_meta,
    output logic                 ipv4_out_rdy,
    input  logic                 ipv4_out_req,
    input  logic                 ipv4_out_acc,
    input  logic                 ipv4_out_done,
    // status
    output logic       [W-1:0]   grant,
    output logic                 busy,
    output logic                 tmo
);

    // Counter value seen on the last cycle before a timeout release
    localparam logic [CNT_W-1:0] ACC_LIM  = CNT_W'(ACC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_LIM = CNT_W'(DONE_TIMEOUT - 1);

    ipv4_arb_state_t  state_q, state_d;
    logic [W-1:0]     grant_q, grant_d;
    logic [W-1:0]     ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             tmo_q,   tmo_d;

    logic [W-1:0]     pick_idx;
    logic             pick_found;
    logic [W-1:0]     grant_nxt;

    ipv4_strm_t       strm_arr [N];
    ipv4_meta_t       meta_arr [N];
    logic             rdy_arr  [N];

    // Per-source views so the mux below is a plain index by grant
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign strm_arr[gi] = ipv4_in_strm[gi];
        assign meta_arr[gi] = ipv4_in_meta[gi];
        assign rdy_arr[gi]  = ipv4_in_rdy[gi];
    end

    eth_vlg_rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req   (ipv4_in_rdy),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // After a release the search starts just past the previous owner
    assign grant_nxt = (grant_q == W'(N - 1)) ? '0 : grant_q + W'(1);

    // Next-state, grant, pointer and watchdog computation
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // acc outranks a same-cycle withdrawal or timeout
                if (ipv4_out_acc) begin
                    state_d = XFER;
                end else if (!rdy_arr[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = grant_nxt;
                end else if (cnt_q >= ACC_LIM) begin
                    state_d = IDLE;
                    ptr_d   = grant_nxt;
                    tmo_d   = 1'b1;
                end
            end
            XFER: begin
                // done outranks a same-cycle timeout, so no tmo then
                if (ipv4_out_done) begin
                    state_d = IDLE;
                    ptr_d   = grant_nxt;
                end else if (cnt_q >= DONE_LIM) begin
                    state_d = IDLE;
                    ptr_d   = grant_nxt;
                    tmo_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        busy_d = (state_d != IDLE);
    end

    // Arbiter state and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    // Forward path: owner's stream to the engine, zeros while idle
    always_comb begin
        ipv4_out_strm = '0;
        ipv4_out_meta = '0;
        ipv4_out_rdy  = 1'b0;
        if (busy_q) begin
            ipv4_out_strm = strm_arr[grant_q];
            ipv4_out_meta = meta_arr[grant_q];
            ipv4_out_rdy  = rdy_arr[grant_q];
        end
    end

    // Return path: only the current owner sees the engine handshake
    for (genvar gr = 0; gr < N; gr++) begin : g_ret
        assign ipv4_in_req[gr]  = busy_q && (grant_q == W'(gr)) && ipv4_out_req;
        assign ipv4_in_acc[gr]  = busy_q && (grant_q == W'(gr)) && ipv4_out_acc;
        assign ipv4_in_done[gr] = busy_q && (grant_q == W'(gr)) && ipv4_out_done;
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign tmo   = tmo_q;

endmodule
`default_nettype wire
